instr_prefetch_queue: RTL and testbench

Decouples the fetch stage from a variable-latency instruction memory.
- Issues sequential 16-bit fetch requests ahead of the pipeline and buffers returned instructions with their PCs.
- Presents InstrF/PCF/PCPlus4F to the fetch stage, which consumes them and honours StallF.
- A taken branch or jump (PCSrcE/PCTargetE from execute) flushes the queue and restarts fetching at the target.
- Responses still in flight from the old stream are discarded.

---
 rtl/pfq_pkg.sv | 17 +
 rtl/pfq_entry_array.sv | 54 +++++
 rtl/instr_prefetch_queue.sv | 164 ++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pfq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package pfq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pfq_state_e;

    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam int          DEF_PC_STEP  = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pfq_entry_array.sv
// Prefetch slot storage: pc, instruction and fill bit per slot.
module pfq_entry_array
    import pfq_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = 16,
    parameter  int DW    = 16,
    localparam int IW    = ptr_w(DEPTH) - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_rsv_en,
    input  logic [IW-1:0] i_rsv_idx,
    input  logic [AW-1:0] i_rsv_pc,
    input  logic          i_fill_en,
    input  logic [IW-1:0] i_fill_idx,
    input  logic [DW-1:0] i_fill_data,
    input  logic [IW-1:0] i_rd_idx,
    output logic [AW-1:0] o_rd_pc,
    output logic [DW-1:0] o_rd_instr,
    output logic          o_rd_fill
);

    logic [AW-1:0]    r_pc    [DEPTH];
    logic [DW-1:0]    r_instr [DEPTH];
    logic [DEPTH-1:0] r_fill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
            r_fill <= '0;
        end else if (i_clr) begin
            r_fill <= '0;
        end else begin
            if (i_rsv_en) begin
                r_pc[i_rsv_idx]   <= i_rsv_pc;
                r_fill[i_rsv_idx] <= 1'b0;
            end
            if (i_fill_en) begin
                r_instr[i_fill_idx] <= i_fill_data;
                r_fill[i_fill_idx]  <= 1'b1;
            end
        end
    end

    assign o_rd_pc    = r_pc[i_rd_idx];
    assign o_rd_instr = r_instr[i_rd_idx];
    assign o_rd_fill  = r_fill[i_rd_idx];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Prefetch queue between fetch and a variable-latency instruction memory.
// Define PFQ_PERF_CNT_EN to add drop / empty-cycle performance counters.
module instr_prefetch_queue
    import pfq_pkg::*;
#(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 16,
    parameter int            DW       = 16,
    parameter int            PC_STEP  = DEF_PC_STEP,
    parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          StallF,
    input  logic          PCSrcE,
    input  logic [AW-1:0] PCTargetE,
    output logic          ValidF,
    output logic [DW-1:0] InstrF,
    output logic [AW-1:0] PCF,
    output logic [AW-1:0] PCPlus4F,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
`ifdef PFQ_PERF_CNT_EN
    output logic [15:0]   perf_drop_cnt,
    output logic [15:0]   perf_empty_cnt,
`endif
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_resp_data
);

    localparam int PW = ptr_w(DEPTH);
    localparam int IW = PW - 1;

    pfq_state_e r_state, w_state_nxt;

    logic [PW-1:0] r_alloc, r_fill, r_rd, r_disc;
    logic [AW-1:0] r_next_pc;

    logic          w_redir, w_accept, w_resp_keep, w_pop, w_room;
    logic [PW-1:0] w_reserved, w_outst;
    logic [PW:0]   w_budget;
    logic [AW-1:0] w_head_pc;
    logic [DW-1:0] w_head_instr;
    logic          w_head_fill;

    assign w_redir     = PCSrcE && (r_state != IDLE);
    assign w_accept    = mem_req_valid && mem_req_ready;
    assign w_resp_keep = mem_resp_valid && !w_redir && (r_disc == '0);
    assign w_pop       = w_head_fill && !StallF && !PCSrcE;
    assign w_reserved  = r_alloc - r_rd;
    assign w_outst     = r_alloc - r_fill;

    // Old-stream responses still in flight count against the budget,
    // so total in-flight requests never exceed DEPTH.
    assign w_budget = {1'b0, w_reserved} + {1'b0, r_disc};
    assign w_room   = w_budget < (PW+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alloc   <= '0;
            r_fill    <= '0;
            r_rd      <= '0;
            r_disc    <= '0;
            r_next_pc <= RESET_PC;
        end else if (w_redir) begin
            r_alloc   <= '0;
            r_fill    <= '0;
            r_rd      <= '0;
            r_disc    <= r_disc + w_outst - PW'(mem_resp_valid);
            r_next_pc <= PCTargetE;
        end else begin
            if (w_accept) begin
                r_alloc   <= r_alloc + PW'(1);
                r_next_pc <= r_next_pc + AW'(PC_STEP);
            end
            if (w_resp_keep) begin
                r_fill <= r_fill + PW'(1);
            end else if (mem_resp_valid) begin
                r_disc <= r_disc - PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = RUN;
            RUN:     w_state_nxt = PCSrcE ? FLUSH : RUN;
            FLUSH:   w_state_nxt = PCSrcE ? FLUSH : RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        unique case (r_state)
            RUN:     mem_req_valid = !PCSrcE && w_room;
            default: mem_req_valid = 1'b0;
        endcase
    end

    assign mem_req_addr = r_next_pc;

    pfq_entry_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_entries (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_redir),
        .i_rsv_en    (w_accept),
        .i_rsv_idx   (r_alloc[IW-1:0]),
        .i_rsv_pc    (r_next_pc),
        .i_fill_en   (w_resp_keep),
        .i_fill_idx  (r_fill[IW-1:0]),
        .i_fill_data (mem_resp_data),
        .i_rd_idx    (r_rd[IW-1:0]),
        .o_rd_pc     (w_head_pc),
        .o_rd_instr  (w_head_instr),
        .o_rd_fill   (w_head_fill)
    );

    // Head fields read as zero while no filled slot is presented.
    assign ValidF   = w_head_fill;
    assign InstrF   = w_head_fill ? w_head_instr : '0;
    assign PCF      = w_head_fill ? w_head_pc : '0;
    assign PCPlus4F = w_head_fill ? w_head_pc + AW'(PC_STEP) : '0;

`ifdef PFQ_PERF_CNT_EN
    logic [15:0] r_drop_cnt, r_empty_cnt;
    logic        w_drop;

    assign w_drop = mem_resp_valid && !w_resp_keep;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt  <= '0;
            r_empty_cnt <= '0;
        end else begin
            if (w_drop && r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 16'd1;
            if (!w_head_fill && !StallF && r_empty_cnt != 16'hFFFF)
                r_empty_cnt <= r_empty_cnt + 16'd1;
        end
    end

    assign perf_drop_cnt  = r_drop_cnt;
    assign perf_empty_cnt = r_empty_cnt;
`endif

    a_resp_legal: assert property (@(posedge clk) disable iff (!rst)
        mem_resp_valid |-> (w_outst != '0 || r_disc != '0));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order latency memory.
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [15:0] PCTargetE = '0;
    logic        ValidF;
    logic [15:0] InstrF, PCF, PCPlus4F;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [15:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [15:0] mem_resp_data = '0;
`ifdef PFQ_PERF_CNT_EN
    logic [15:0] drop_cnt, empty_cnt;
`endif

    always #5 clk = ~clk;

    instr_prefetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .StallF         (StallF),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .ValidF         (ValidF),
        .InstrF         (InstrF),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
`ifdef PFQ_PERF_CNT_EN
        .perf_drop_cnt  (drop_cnt),
        .perf_empty_cnt (empty_cnt),
`endif
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_req = 0;
    logic [15:0] exp_pc = '0;
    logic [15:0] exp_req = '0;
    logic [15:0] q_addr[$];
    int          q_due[$];

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock: check the head, drive memory, record requests, advance.
    task automatic tick(input logic stall, input logic redir,
                        input logic [15:0] tgt);
        StallF    = stall;
        PCSrcE    = redir;
        PCTargetE = tgt;
        if (ValidF === 1'b1) begin
            chk("head_pc", PCF, exp_pc);
            chk("head_instr", InstrF, ~exp_pc);
            chk("head_pc4", PCPlus4F, exp_pc + 16'd4);
        end
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = ~q_addr[0];
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        #1;
        if (redir) chk("req_in_redir", 16'(mem_req_valid), 16'd0);
        if (mem_req_valid && mem_req_ready) begin
            chk("req_addr", mem_req_addr, exp_req);
            q_addr.push_back(mem_req_addr);
            q_due.push_back(cyc + lat);
            exp_req = exp_req + 16'd4;
            n_req++;
        end
        if (redir) begin
            exp_pc  = tgt;
            exp_req = tgt;
        end else if (ValidF && !stall) begin
            exp_pc = exp_pc + 16'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        PCSrcE = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30 && !ValidF; i++) tick(1'b0, 1'b0, 16'h0);
        chk(tag, 16'(ValidF), 16'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 16'(ValidF), 16'd0);
        chk({tag, "_instr"}, InstrF, 16'h0);
        chk({tag, "_pcf"}, PCF, 16'h0);
        chk({tag, "_pc4"}, PCPlus4F, 16'h0);
        chk({tag, "_reqv"}, 16'(mem_req_valid), 16'd0);
        chk({tag, "_addr"}, mem_req_addr, 16'h0000);
    endtask

    initial begin
        // Power-on reset, then 1-cycle memory streaming
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        chk("idle_noreq", 16'(mem_req_valid), 16'd0);
        tick(1'b0, 1'b0, 16'h0);
        chk("run_req", 16'(mem_req_valid), 16'd1);
        chk("lat_v0a", 16'(ValidF), 16'd0);
        tick(1'b0, 1'b0, 16'h0);
        chk("lat_v0b", 16'(ValidF), 16'd0);
        tick(1'b0, 1'b0, 16'h0);
        chk("first_valid", 16'(ValidF), 16'd1);
        chk("first_pcf", PCF, 16'h0000);
        chk("first_pc4", PCPlus4F, 16'h0004);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 16'h0);
            chk("thruput", 16'(ValidF), 16'd1);
        end

        // Asynchronous reset with responses still pending
        lat = 3;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 16'h0);
        chk("pend_ge2", 16'(q_addr.size() >= 2), 16'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        q_addr.delete();
        q_due.delete();
        exp_pc  = 16'h0000;
        exp_req = 16'h0000;
        @(negedge clk);

        // Stall from reset release: queue fills and issue stops
        lat   = 1;
        n_req = 0;
        rst   = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 16'h0);
        chk("stall_nreq", 16'(n_req), 16'd4);
        chk("stall_reqoff", 16'(mem_req_valid), 16'd0);
        chk("stall_valid", 16'(ValidF), 16'd1);
        chk("stall_pcf", PCF, 16'h0000);
        chk("stall_instr", InstrF, 16'hFFFF);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'h0);
        chk("drain_pcf", PCF, 16'h0020);

        // Redirect with latency 3 and old requests in flight
        lat = 3;
        for (int i = 0; i < 20 && q_addr.size() < 3; i++)
            tick(1'b0, 1'b0, 16'h0);
        chk("lat3_pend", 16'(q_addr.size() >= 3), 16'd1);
        tick(1'b0, 1'b1, 16'h0040);
        chk("redir_v0", 16'(ValidF), 16'd0);
        wait_valid("redir_seen");
        chk("redir_pcf", PCF, 16'h0040);
        chk("redir_instr", InstrF, 16'hFFBF);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 16'h0);

        // Redirect coinciding with a response and a pop
        lat = 1;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 16'h0);
        chk("rp_pre_valid", 16'(ValidF), 16'd1);
        tick(1'b0, 1'b1, 16'h0080);
        chk("rp_v0", 16'(ValidF), 16'd0);
        wait_valid("rp_seen");
        chk("rp_pcf", PCF, 16'h0080);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0);

        // Back-to-back redirects: only the newer stream survives
        tick(1'b0, 1'b1, 16'h0100);
        tick(1'b0, 1'b1, 16'h0200);
        chk("b2b_v0", 16'(ValidF), 16'd0);
        wait_valid("b2b_seen");
        chk("b2b_pcf", PCF, 16'h0200);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 16'h0);

        // PC wraps past the top of the address space
        tick(1'b0, 1'b1, 16'hFFF8);
        wait_valid("wrap_seen");
        chk("wrap_pcf0", PCF, 16'hFFF8);
        tick(1'b0, 1'b0, 16'h0);
        chk("wrap_pcf1", PCF, 16'hFFFC);
        chk("wrap_pc4", PCPlus4F, 16'h0000);
        tick(1'b0, 1'b0, 16'h0);
        chk("wrap_pcf2", PCF, 16'h0000);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
